// File: rtl/mda_pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles, with loss-of-signal timeout.
// Define MDA_PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-sample glitch filter ahead of edge detection.
module mda_pwm_capture #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
   parameter int unsigned FILTER_LEN     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pwm_in,
   output logic [15:0] period,
   output logic [15:0] duty_cycle,
   output logic        valid,
   output logic        timeout,
   output logic        stuck_level
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      LOW_WAIT,
      HIGH
   } state_t;

   state_t      state_q;
   logic        s1_q, s2_q, s3_q;
   logic        lvl;
   logic        rise, fall, hit;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] high_cnt_q;
   logic [15:0] period_q, duty_q;
   logic        valid_q, timeout_q, stuck_q;

   if (TIMEOUT_CYCLES < 16'd2) begin : g_bad_timeout
      $error("mda_pwm_capture: TIMEOUT_CYCLES must be in 2..65535");
   end
   if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
      $error("mda_pwm_capture: FILTER_LEN must be in 1..15");
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= pwm_in;
         s2_q <= s1_q;
         s3_q <= lvl;
      end
   end

`ifdef MDA_PWM_CAPTURE_FILTER_EN
   localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);

   logic       filt_q;
   logic [3:0] fcnt_q;

   // Filtered level follows s2 only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else if (s2_q == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FLT_MAX) begin
         filt_q <= s2_q;
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 4'd1;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = s2_q;
`endif

   assign rise = lvl & ~s3_q;
   assign fall = ~lvl & s3_q;

   // An edge on the threshold cycle takes precedence over the timeout.
   assign hit = (cnt_q == TIMEOUT_CYCLES) && !rise && !fall &&
                !(state_q == IDLE && timeout_q);

   always_comb begin
      cnt_d = cnt_q;
      if (rise) begin
         cnt_d = 16'd1;
      end else if (state_q == IDLE && timeout_q) begin
         cnt_d = cnt_q;
      end else if (cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         high_cnt_q <= '0;
         period_q   <= '0;
         duty_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= 1'b0;
         if (hit) begin
            period_q  <= '0;
            duty_q    <= '0;
            timeout_q <= 1'b1;
            stuck_q   <= s2_q;
            state_q   <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise) state_q <= ARMED;
               end
               ARMED: begin
                  if (fall) begin
                     high_cnt_q <= cnt_q;
                     state_q    <= LOW_WAIT;
                  end
               end
               LOW_WAIT: begin
                  if (rise) begin
                     period_q  <= cnt_q;
                     duty_q    <= high_cnt_q;
                     valid_q   <= 1'b1;
                     timeout_q <= 1'b0;
                     state_q   <= HIGH;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     high_cnt_q <= cnt_q;
                     state_q    <= LOW_WAIT;
                  end else if (rise) begin
                     state_q <= ARMED;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign period      = period_q;
   assign duty_cycle  = duty_q;
   assign valid       = valid_q;
   assign timeout     = timeout_q;
   assign stuck_level = stuck_q;

endmodule
